// File: rtl/arbitro_registrador_if.sv
// Bus between the two writers, the shared 8-bit register and the arbiter.
// slave: the arbiter's view. master: the environment (writers + register).
interface arbitro_registrador_if #(
    parameter int LARGURA = 8
);
    logic               req_a;
    logic [LARGURA-1:0] dado_a;
    logic               ack_a;
    logic               req_b;
    logic [LARGURA-1:0] dado_b;
    logic               ack_b;
    logic [LARGURA-1:0] reg_q;
    logic [LARGURA-1:0] reg_d;
    logic               reg_preset;
    logic               reg_clear;
    logic               ocupado;
    logic [7:0]         escritas;

    modport slave (
        input  req_a, dado_a, req_b, dado_b, reg_q,
        output ack_a, ack_b, reg_d, reg_preset, reg_clear, ocupado, escritas
    );

    modport master (
        output req_a, dado_a, req_b, dado_b, reg_q,
        input  ack_a, ack_b, reg_d, reg_preset, reg_clear, ocupado, escritas
    );
endinterface

// File: rtl/arbitro_registrador.sv
// Round-robin arbiter sharing one enable-less register between writers A and B.
// The register's D is recirculated from Q except for the single ESCRITA cycle,
// when the granted writer's data is substituted. Four-phase req/ack per writer.
module arbitro_registrador #(
    parameter int LARGURA = 8
) (
    input  logic                  clk,
    input  logic                  clear,
    arbitro_registrador_if.slave  bus
);

    typedef enum logic [2:0] {
        LIVRE,
        ESCRITA_A,
        ESCRITA_B,
        ESPERA_A,
        ESPERA_B
    } estado_t;

    estado_t    estado, prox;
    logic       ultimo;      // last writer served: 0 = A, 1 = B
    logic [7:0] escritas;

    // Register clear follows the block reset directly; preset is never used.
    assign bus.reg_clear  = clear;
    assign bus.reg_preset = 1'b0;
    assign bus.escritas   = escritas;

    // State register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) estado <= LIVRE;
        else       estado <= prox;
    end

    // Next state and state-decoded outputs (no combinational path from req).
    always_comb begin
        prox        = estado;
        bus.reg_d   = bus.reg_q;
        bus.ack_a   = 1'b0;
        bus.ack_b   = 1'b0;
        bus.ocupado = (estado != LIVRE);
        case (estado)
            LIVRE: begin
                if (bus.req_a && bus.req_b) prox = ultimo ? ESCRITA_A : ESCRITA_B;
                else if (bus.req_a)         prox = ESCRITA_A;
                else if (bus.req_b)         prox = ESCRITA_B;
            end
            ESCRITA_A: begin
                bus.reg_d = bus.dado_a;
                prox      = ESPERA_A;
            end
            ESCRITA_B: begin
                bus.reg_d = bus.dado_b;
                prox      = ESPERA_B;
            end
            ESPERA_A: begin
                bus.ack_a = 1'b1;
                if (!bus.req_a) prox = LIVRE;
            end
            ESPERA_B: begin
                bus.ack_b = 1'b1;
                if (!bus.req_b) prox = LIVRE;
            end
            default: prox = LIVRE;
        endcase
    end

    // Round-robin pointer and write counter advance on the edge that ends ESCRITA.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            ultimo   <= 1'b1;
            escritas <= 8'd0;
        end else if (estado == ESCRITA_A) begin
            ultimo   <= 1'b0;
            escritas <= escritas + 8'd1;
        end else if (estado == ESCRITA_B) begin
            ultimo   <= 1'b1;
            escritas <= escritas + 8'd1;
        end
    end

endmodule

// File: tb/tb_arbitro_registrador.sv
// Directed bench for arbitro_registrador with a behavioural model of the
// shared 8-bit register hanging off reg_d/reg_q.
module tb_arbitro_registrador;

    logic clk = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;

    arbitro_registrador_if #(.LARGURA(8)) bus ();

    arbitro_registrador #(.LARGURA(8)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register model: async clear, async preset, otherwise captures D.
    logic       rclr, rpre;
    logic [7:0] q;
    assign rclr = bus.reg_clear;
    assign rpre = bus.reg_preset;
    always_ff @(posedge clk or posedge rclr or posedge rpre) begin
        if (rclr)      q <= 8'h00;
        else if (rpre) q <= 8'hFF;
        else           q <= bus.reg_d;
    end
    assign bus.reg_q = q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clear = 1'b1;
        bus.req_a = 1'b0; bus.dado_a = 8'h00;
        bus.req_b = 1'b0; bus.dado_b = 8'h00;
        tick(); tick();

        // Reset state
        chk("rst_ack_a",   bus.ack_a, 0);
        chk("rst_ack_b",   bus.ack_b, 0);
        chk("rst_ocupado", bus.ocupado, 0);
        chk("rst_escritas", bus.escritas, 0);
        chk("rst_reg_clear", bus.reg_clear, 1);
        chk("rst_reg_preset", bus.reg_preset, 0);
        chk("rst_reg_q", bus.reg_q, 8'h00);
        clear = 1'b0;
        tick();
        chk("idle_reg_d", bus.reg_d, 8'h00);
        chk("idle_reg_clear", bus.reg_clear, 0);

        // Single write from A
        bus.req_a = 1'b1; bus.dado_a = 8'hA5;
        tick();
        chk("sw_esc_reg_d", bus.reg_d, 8'hA5);
        chk("sw_esc_ocupado", bus.ocupado, 1);
        chk("sw_esc_ack_a", bus.ack_a, 0);
        tick();
        chk("sw_reg_q", bus.reg_q, 8'hA5);
        chk("sw_ack_a", bus.ack_a, 1);
        chk("sw_escritas", bus.escritas, 1);
        tick();
        chk("sw_ack_held", bus.ack_a, 1);
        bus.req_a = 1'b0;
        tick();
        chk("sw_ack_drop", bus.ack_a, 0);
        chk("sw_ocupado_drop", bus.ocupado, 0);
        chk("sw_reg_q_hold", bus.reg_q, 8'hA5);

        // Tie and round-robin, from reset
        clear = 1'b1; tick(); clear = 1'b0;
        chk("rr_rst_reg_q", bus.reg_q, 8'h00);
        bus.req_a = 1'b1; bus.dado_a = 8'h11;
        bus.req_b = 1'b1; bus.dado_b = 8'h22;
        tick();
        chk("rr1_reg_d", bus.reg_d, 8'h11);
        tick();
        chk("rr1_reg_q", bus.reg_q, 8'h11);
        chk("rr1_ack_a", bus.ack_a, 1);
        chk("rr1_ack_b", bus.ack_b, 0);
        bus.req_a = 1'b0;
        tick();
        chk("rr1_livre", bus.ocupado, 0);
        bus.req_a = 1'b1;
        tick();
        chk("rr2_reg_d", bus.reg_d, 8'h22);
        tick();
        chk("rr2_reg_q", bus.reg_q, 8'h22);
        chk("rr2_ack_b", bus.ack_b, 1);
        chk("rr2_ack_a", bus.ack_a, 0);
        bus.req_b = 1'b0;
        tick();
        chk("rr2_livre", bus.ocupado, 0);
        tick();
        chk("rr3_reg_d", bus.reg_d, 8'h11);
        tick();
        chk("rr3_reg_q", bus.reg_q, 8'h11);
        chk("rr3_ack_a", bus.ack_a, 1);
        chk("rr3_escritas", bus.escritas, 3);
        bus.req_a = 1'b0;
        tick();

        // Hold: write 3C, then 10 idle cycles
        bus.req_a = 1'b1; bus.dado_a = 8'h3C;
        tick(); tick();
        bus.req_a = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_reg_q", bus.reg_q, 8'h3C);
            chk("hold_ocupado", bus.ocupado, 0);
        end
        chk("hold_escritas", bus.escritas, 4);

        // Abort during ESCRITA_B
        clear = 1'b1; tick(); clear = 1'b0;
        bus.req_b = 1'b1; bus.dado_b = 8'hFF;
        tick();
        chk("ab_esc_reg_d", bus.reg_d, 8'hFF);
        #2 clear = 1'b1;
        #1;
        chk("ab_async_ocupado", bus.ocupado, 0);
        chk("ab_async_reg_q", bus.reg_q, 8'h00);
        tick();
        chk("ab_reg_q", bus.reg_q, 8'h00);
        chk("ab_ack_b", bus.ack_b, 0);
        bus.req_b = 1'b0;
        clear = 1'b0;
        tick();
        chk("ab_ack_b2", bus.ack_b, 0);
        chk("ab_escritas", bus.escritas, 0);
        chk("ab_reg_q2", bus.reg_q, 8'h00);

        // Held request across clear is granted at the first edge
        bus.req_b = 1'b1; bus.dado_b = 8'hC3;
        clear = 1'b1;
        tick();
        chk("hc_clear_ocupado", bus.ocupado, 0);
        clear = 1'b0;
        tick();
        chk("hc_ocupado", bus.ocupado, 1);
        chk("hc_reg_d", bus.reg_d, 8'hC3);
        tick();
        chk("hc_ack_b", bus.ack_b, 1);
        chk("hc_reg_q", bus.reg_q, 8'hC3);
        bus.req_b = 1'b0;
        tick();

        // Wrap: 256 writes of 5A from a clean counter
        clear = 1'b1; tick(); clear = 1'b0;
        bus.dado_a = 8'h5A;
        for (int i = 0; i < 256; i++) begin
            bus.req_a = 1'b1;
            tick(); tick();
            bus.req_a = 1'b0;
            tick();
            if (i == 254) chk("wrap_255", bus.escritas, 255);
        end
        chk("wrap_0", bus.escritas, 0);
        chk("wrap_reg_q", bus.reg_q, 8'h5A);

        // Violation: req_a drops during ESCRITA_A
        bus.req_a = 1'b1; bus.dado_a = 8'h77;
        tick();
        chk("vi_reg_d", bus.reg_d, 8'h77);
        bus.req_a = 1'b0;
        tick();
        chk("vi_ack_pulse", bus.ack_a, 1);
        chk("vi_reg_q", bus.reg_q, 8'h77);
        chk("vi_escritas", bus.escritas, 1);
        tick();
        chk("vi_ack_end", bus.ack_a, 0);
        chk("vi_ocupado", bus.ocupado, 0);
        chk("vi_reg_q_hold", bus.reg_q, 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_registrador.md
Name: arbitro_registrador

Overview:
- Arbiter and controller that shares one 8-bit D-flip-flop register (registrador_8bits) between two writers, A and B.
- The register has no load enable, so this block drives the register's D bus: it recirculates the register's Q while idle and substitutes the granted writer's data for exactly one clock.
- Each writer uses a four-phase req/ack handshake. Simultaneous requests are resolved round-robin.
- Sits between the requesting units and the register instance; the register's clk and clear are shared with this block.

Parameters:
- LARGURA, 8, data width of the register and of both writer buses.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clear  input  1  reset, asynchronous, active-high; also forwarded to the register.
- req_a  input  1  write request from writer A.
- dado_a  input  LARGURA  write data from A; must be stable while req_a=1 and ack_a=0.
- ack_a  output  1  A's write is complete; held until req_a is sampled low.
- req_b  input  1  write request from writer B.
- dado_b  input  LARGURA  write data from B; same stability rule as A.
- ack_b  output  1  B's write is complete.
- reg_q  input  LARGURA  current Q output of the register.
- reg_d  output  LARGURA  D input of the register.
- reg_preset  output  1  register preset; tied to 0.
- reg_clear  output  1  register clear; equals clear, combinationally.
- ocupado  output  1  high in any state other than LIVRE.
- escritas  output  8  count of completed writes; wraps 255->0.

Behaviour:
- Reset is asynchronous: clear=1 forces the following, regardless of clk.
  - State = LIVRE; ack_a=ack_b=0.
  - ultimo=B, so A wins the first tie.
  - escritas=0.
  - The register clears through reg_clear.
- States and transitions:
  - LIVRE:
    - req_a & !req_b -> ESCRITA_A.
    - req_b & !req_a -> ESCRITA_B.
    - req_a & req_b -> ESCRITA_x, where x is not ultimo.
    - No request -> stay in LIVRE.
  - ESCRITA_x: lasts one cycle.
    - reg_d = dado_x.
    - At the next edge: the register captures dado_x, ultimo<=x, escritas<=escritas+1, state -> ESPERA_x.
  - ESPERA_x:
    - ack_x=1.
    - req_x sampled 0 -> LIVRE (ack_x drops that edge); otherwise stay.
- reg_d = reg_q in every state except ESCRITA_x, so the register holds its value.
- ack_a, ack_b and ocupado decode from the registered state only; they never depend combinationally on req.
- Latency:
  - req_x is sampled at edge n; ESCRITA_x runs from edge n to n+1.
  - reg_q = dado_x and ack_x=1 from edge n+1.
  - Minimum transaction length is 3 cycles to LIVRE.
  - A back-to-back grant is possible the cycle after LIVRE is re-entered.
- ack_a and ack_b are never both 1. At most one write happens per ESCRITA state.
- Boundary cases:
  - A requester that holds req while the other is served wins the next arbitration via round-robin; no starvation.
  - req_x dropping during ESCRITA_x (protocol violation): the write still completes, and ESPERA_x lasts one cycle (a 1-cycle ack pulse).
  - A new req_x during ESPERA_x is not a new request. A fresh write requires req_x low, then high again.
  - clear asserted mid-transaction aborts it: no write, no count, ack cleared, register cleared.
  - After clear deasserts, a held req is granted at the first edge.
  - escritas at 255 plus one write -> 0.

Test Plan:
- Reset: clear=1 with reg_q arbitrary -> ack_a=ack_b=0, ocupado=0, escritas=0, reg_clear=1, reg_preset=0. Release clear -> reg_d tracks reg_q.
- Single write: req_a=1, dado_a=8'hA5 -> reg_d=A5 for one cycle, reg_q=A5 and ack_a=1 one edge later, escritas=1. Drop req_a -> ack_a=0 next edge, reg_q stays A5.
- Tie and round-robin: from reset, req_a=req_b=1 with dado_a=8'h11, dado_b=8'h22.
  - A is served first (reg_q=11).
  - A then drops req_a and immediately re-asserts it -> B is served next (reg_q=22), then A again.
  - escritas=3.
- Hold: no requests for 10 cycles after writing 8'h3C -> reg_q=3C throughout, ocupado=0.
- Abort: clear pulse during ESCRITA_B with dado_b=8'hFF -> reg_q=00, ack_b never asserts, escritas unchanged (0).
- Wrap and violation:
  - 256 writes of 8'h5A -> escritas wraps to 0.
  - req_a dropped in the ESCRITA_A cycle -> ack_a is a one-cycle pulse and the write still lands.
